// File: rtl/encryption_process.sv
// ACORN-128 encryption phase: one StateUpdate128 step per plaintext handshake, then 256 pad steps.
// Optional macro ENC_BITCOUNT_EN adds the pt_count output.
module encryption_process #(
    parameter int unsigned MAX_PT_BITS = 4095
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [292:0] state_in,
    input  logic         pt_bit,
    input  logic         pt_valid,
    input  logic         pt_last,
    output logic         pt_ready,
    output logic         ct_bit,
    output logic         ct_valid,
    output logic [292:0] state_out,
`ifdef ENC_BITCOUNT_EN
    output logic [11:0]  pt_count,
`endif
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StEnc, StPad, StDone} state_e;

    localparam logic [11:0] MaxBits = 12'(MAX_PT_BITS);

    state_e       st_q, st_d;
    logic [292:0] state_q, state_d;
    logic [11:0]  hs_cnt_q, hs_cnt_d;
    logic [7:0]   pad_cnt_q, pad_cnt_d;
    logic         ct_bit_q, ct_bit_d;
    logic         ct_valid_q, ct_valid_d;

    logic         handshake;
    logic         m, ca, cb, ks, fb;
    logic [292:0] s_mix, s_next;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    assign pt_ready  = (st_q == StEnc);
    assign done      = (st_q == StDone);
    assign handshake = pt_valid & pt_ready;

    // Single step datapath shared by ENC and PAD; only m and ca differ.
    always_comb begin
        m  = 1'b0;
        ca = 1'b1;
        cb = 1'b0;
        if (st_q == StEnc) begin
            m = pt_bit;
        end else if (st_q == StPad) begin
            m  = (pad_cnt_q == 8'd0);
            ca = ~pad_cnt_q[7];
        end

        s_mix      = state_q;
        s_mix[289] = s_mix[289] ^ s_mix[235] ^ s_mix[230];
        s_mix[230] = s_mix[230] ^ s_mix[196] ^ s_mix[193];
        s_mix[193] = s_mix[193] ^ s_mix[160] ^ s_mix[154];
        s_mix[154] = s_mix[154] ^ s_mix[111] ^ s_mix[107];
        s_mix[107] = s_mix[107] ^ s_mix[66] ^ s_mix[61];
        s_mix[61]  = s_mix[61] ^ s_mix[23] ^ s_mix[0];

        ks = s_mix[12] ^ s_mix[154] ^ maj(s_mix[235], s_mix[61], s_mix[193])
             ^ ch(s_mix[230], s_mix[111], s_mix[66]);
        fb = s_mix[0] ^ ~s_mix[107] ^ maj(s_mix[244], s_mix[23], s_mix[160])
             ^ (ca & s_mix[196]) ^ (cb & ks);
        s_next = {fb ^ m, s_mix[292:1]};
    end

    always_comb begin
        st_d       = st_q;
        state_d    = state_q;
        hs_cnt_d   = hs_cnt_q;
        pad_cnt_d  = pad_cnt_q;
        ct_bit_d   = ct_bit_q;
        ct_valid_d = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    st_d      = StEnc;
                    state_d   = state_in;
                    hs_cnt_d  = '0;
                    pad_cnt_d = '0;
                end
            end
            StEnc: begin
                if (handshake) begin
                    state_d    = s_next;
                    ct_bit_d   = pt_bit ^ ks;
                    ct_valid_d = 1'b1;
                    if (hs_cnt_q != 12'hfff) begin
                        hs_cnt_d = hs_cnt_q + 12'd1;
                    end
                    if (pt_last || (hs_cnt_q + 12'd1) == MaxBits) begin
                        st_d = StPad;
                    end
                end
            end
            StPad: begin
                state_d = s_next;
                if (pad_cnt_q == 8'd255) begin
                    st_d = StDone;
                end else begin
                    pad_cnt_d = pad_cnt_q + 8'd1;
                end
            end
            StDone: st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= StIdle;
            state_q    <= '0;
            hs_cnt_q   <= '0;
            pad_cnt_q  <= '0;
            ct_bit_q   <= 1'b0;
            ct_valid_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            state_q    <= state_d;
            hs_cnt_q   <= hs_cnt_d;
            pad_cnt_q  <= pad_cnt_d;
            ct_bit_q   <= ct_bit_d;
            ct_valid_q <= ct_valid_d;
        end
    end

    assign ct_bit    = ct_bit_q;
    assign ct_valid  = ct_valid_q;
    assign state_out = state_q;

`ifdef ENC_BITCOUNT_EN
    logic [11:0] pt_count_q;

    // Latched on PAD entry so it stays stable until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pt_count_q <= '0;
        end else if (st_q == StIdle && start) begin
            pt_count_q <= '0;
        end else if (st_q == StEnc && st_d == StPad) begin
            pt_count_q <= hs_cnt_d;
        end
    end

    assign pt_count = pt_count_q;
`endif

endmodule

// File: tb/tb_encryption_process.sv
// Self-checking bench for encryption_process: scoreboard of ciphertext bits plus state checks.
module tb_encryption_process;

    logic         clk = 1'b0;
    logic         rst, start, pt_bit, pt_valid, pt_last;
    logic [292:0] state_in;
    logic         pt_ready, ct_bit, ct_valid, done;
    logic [292:0] state_out;
    logic         start_8, pt_bit_8, pt_valid_8, pt_last_8;
    logic [292:0] state_in_8;
    logic         pt_ready_8, ct_bit_8, ct_valid_8, done_8;
    logic [292:0] state_out_8;
`ifdef ENC_BITCOUNT_EN
    logic [11:0]  pt_count, pt_count_8;
`endif

    int checks = 0;
    int errors = 0;
    logic q_exp[$];
    logic mon_exp;
    logic [292:0] kat_st, kat_final;
    logic [127:0] kat_pt;

    always #5 clk = ~clk;

    encryption_process dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in), .pt_bit(pt_bit),
        .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready), .ct_bit(ct_bit),
        .ct_valid(ct_valid), .state_out(state_out),
`ifdef ENC_BITCOUNT_EN
        .pt_count(pt_count),
`endif
        .done(done)
    );

    encryption_process #(.MAX_PT_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_8), .state_in(state_in_8), .pt_bit(pt_bit_8),
        .pt_valid(pt_valid_8), .pt_last(pt_last_8), .pt_ready(pt_ready_8),
        .ct_bit(ct_bit_8), .ct_valid(ct_valid_8), .state_out(state_out_8),
`ifdef ENC_BITCOUNT_EN
        .pt_count(pt_count_8),
`endif
        .done(done_8)
    );

    // Reference StateUpdate128 step.
    function automatic logic [292:0] model_step(input logic [292:0] s_in, input logic m,
                                                input logic ca, input logic cb,
                                                output logic ks);
        logic [292:0] s;
        logic f;
        s = s_in;
        s[289] ^= s[235] ^ s[230];
        s[230] ^= s[196] ^ s[193];
        s[193] ^= s[160] ^ s[154];
        s[154] ^= s[111] ^ s[107];
        s[107] ^= s[66] ^ s[61];
        s[61]  ^= s[23] ^ s[0];
        ks = s[12] ^ s[154] ^ ((s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]))
             ^ (s[230] ? s[111] : s[66]);
        f = s[0] ^ ~s[107] ^ ((s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]))
            ^ (ca & s[196]) ^ (cb & ks);
        return {f ^ m, s[292:1]};
    endfunction

    function automatic logic [292:0] model_pad(input logic [292:0] s_in);
        logic [292:0] s;
        logic k;
        s = s_in;
        for (int j = 0; j < 256; j++) s = model_step(s, (j == 0), (j < 128), 1'b0, k);
        return s;
    endfunction

    // Scoreboard consumer: every ct_valid strobe must match the next expected bit.
    always @(negedge clk) begin
        if (ct_valid === 1'b1) begin
            checks++;
            if (q_exp.size() == 0) begin
                errors++;
                $display("FAIL ct_unexpected: got ct_valid=1, required no strobe");
            end else begin
                mon_exp = q_exp.pop_front();
                if (ct_bit !== mon_exp) begin
                    errors++;
                    $display("FAIL ct_bit: got %b, required %b", ct_bit, mon_exp);
                end
            end
        end
    end

    // Drives one message; returns the expected final state and the pad cycles observed.
    task automatic run_msg(input logic [292:0] st, input logic [127:0] bits, input int n,
                           input int gap_pct, input bit disturb, input int abort_at,
                           output logic [292:0] model, output int pad_cycles);
        logic [292:0] s;
        logic k, v;
        int i, cyc;
        s = st;
        @(posedge clk); #1;
        start = 1'b1; state_in = st;
        @(posedge clk); #1;
        start = 1'b0; state_in = ~st;
        i = 0; cyc = 0;
        while (i < n && cyc < 2000) begin
            v = ($urandom_range(99) >= gap_pct);
            pt_valid = v; pt_bit = bits[i]; pt_last = (i == n - 1);
            if (disturb && i == n / 2) start = 1'b1;
            if (v) begin
                s = model_step(s, bits[i], 1'b1, 1'b0, k);
                q_exp.push_back(bits[i] ^ k);
                i++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            checks++;
            if (state_out !== s) begin
                errors++;
                $display("FAIL enc_state: cycle %0d valid=%b got %h, required %h",
                         cyc, v, state_out, s);
            end
        end
        pt_valid = 1'b0; pt_last = 1'b0;
        model = model_pad(s);
        pad_cycles = 0;
        while (done !== 1'b1 && pad_cycles < 400) begin
            if (abort_at >= 0 && pad_cycles == abort_at) return;
            if (disturb) begin pt_valid = 1'b1; pt_last = 1'b1; pt_bit = 1'($urandom); end
            @(posedge clk); #1;
            pad_cycles++;
        end
        pt_valid = 1'b0; pt_last = 1'b0;
    endtask

    task automatic check_end(input string name, input logic [292:0] model, input int pc,
                             input int n);
        checks++;
        if (pc !== 256) begin
            errors++;
            $display("FAIL %s_pad_len: got %0d cycles, required 256", name, pc);
        end
        checks++;
        if (state_out !== model) begin
            errors++;
            $display("FAIL %s_state: got %h, required %h", name, state_out, model);
        end
`ifdef ENC_BITCOUNT_EN
        checks++;
        if (pt_count !== 12'(n)) begin
            errors++;
            $display("FAIL %s_pt_count: got %0d, required %0d", name, pt_count, n);
        end
`endif
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL %s_ct_missing: got %0d pending, required 0", name, q_exp.size());
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got done=%b after one cycle, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({ct_bit, ct_valid, pt_ready, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000", {ct_bit, ct_valid, pt_ready, done});
        end
        checks++;
        if (state_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h, required 0", state_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [292:0] model;
        int pc;
        run_msg('0, '0, 1, 0, 1'b0, -1, model, pc);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got %b, required 1", done);
        end
        check_end("zero", model, pc, 1);
    endtask

    task automatic test_kat();
        int pc;
        run_msg(kat_st, kat_pt, 128, 0, 1'b0, -1, kat_final, pc);
        check_end("kat", kat_final, pc, 128);
    endtask

    task automatic test_gaps();
        logic [292:0] model;
        int pc;
        run_msg(kat_st, kat_pt, 64, 50, 1'b0, -1, model, pc);
        check_end("gaps", model, pc, 64);
    endtask

    task automatic test_disturb();
        logic [292:0] model;
        int pc;
        run_msg(kat_st, kat_pt, 128, 0, 1'b1, -1, model, pc);
        check_end("disturb", model, pc, 128);
        checks++;
        if (model !== kat_final) begin
            errors++;
            $display("FAIL disturb_vs_kat: got %h, required %h", model, kat_final);
        end
    endtask

    task automatic test_abort();
        logic [292:0] model;
        int pc;
        run_msg(kat_st, kat_pt, 128, 0, 1'b0, 100, model, pc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({ct_bit, ct_valid, pt_ready, done} !== 4'b0 || state_out !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got flags %b state %h, required all 0",
                     {ct_bit, ct_valid, pt_ready, done}, state_out);
        end
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL abort_done: got done=1 at idle cycle %0d, required 0", c);
                break;
            end
        end
        run_msg(kat_st, kat_pt, 128, 0, 1'b0, -1, model, pc);
        check_end("abort_rerun", model, pc, 128);
        checks++;
        if (model !== kat_final) begin
            errors++;
            $display("FAIL abort_vs_kat: got %h, required %h", model, kat_final);
        end
    endtask

    task automatic test_max_bits();
        logic [292:0] s;
        logic k, exp_ct;
        int strobes, wait_c;
        s = kat_st;
        @(posedge clk); #1;
        start_8 = 1'b1; state_in_8 = kat_st;
        @(posedge clk); #1;
        start_8 = 1'b0; pt_valid_8 = 1'b1; pt_last_8 = 1'b0;
        strobes = 0;
        exp_ct = 1'b0;
        for (int c = 0; c < 20; c++) begin
            pt_bit_8 = kat_pt[c];
            if (c < 8) begin
                s = model_step(s, kat_pt[c], 1'b1, 1'b0, k);
                exp_ct = kat_pt[c] ^ k;
            end
            @(posedge clk); #1;
            if (ct_valid_8 === 1'b1) begin
                strobes++;
                checks++;
                if (ct_bit_8 !== exp_ct) begin
                    errors++;
                    $display("FAIL max_ct_bit: cycle %0d got %b, required %b", c, ct_bit_8, exp_ct);
                end
            end
        end
        pt_valid_8 = 1'b0;
        checks++;
        if (strobes != 8) begin
            errors++;
            $display("FAIL max_strobes: got %0d, required 8", strobes);
        end
        checks++;
        if (pt_ready_8 !== 1'b0) begin
            errors++;
            $display("FAIL max_ready: got %b, required 0", pt_ready_8);
        end
        s = model_pad(s);
        wait_c = 0;
        while (done_8 !== 1'b1 && wait_c < 400) begin
            @(posedge clk); #1;
            wait_c++;
        end
        checks++;
        if (done_8 !== 1'b1 || state_out_8 !== s) begin
            errors++;
            $display("FAIL max_state: got done=%b state %h, required done=1 state %h",
                     done_8, state_out_8, s);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; state_in = '0; pt_bit = 1'b0; pt_valid = 1'b0;
        pt_last = 1'b0;
        start_8 = 1'b0; state_in_8 = '0; pt_bit_8 = 1'b0; pt_valid_8 = 1'b0; pt_last_8 = 1'b0;
        for (int i = 0; i < 293; i++) kat_st[i] = 1'($urandom_range(1));
        for (int i = 0; i < 128; i++) kat_pt[i] = 1'($urandom_range(1));
        test_reset();
        test_zero();
        test_kat();
        test_gaps();
        test_disturb();
        test_abort();
        test_max_bits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
